// File: rtl/opc7_bus_arbiter.sv
// opc7_bus_arbiter: shares one memory/IO port between the opc7 CPU (clock-enable throttled) and a DMA requester.
// Define ARB_CPU_LOCK_EN to add the cpu_lock input for atomic CPU read-modify-write sequences.
module opc7_bus_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              cpu_vpa,
  input  logic              cpu_vda,
  input  logic              cpu_vio,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_clken,
`ifdef ARB_CPU_LOCK_EN
  input  logic              cpu_lock,
`endif
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_cs,
  output logic              mem_io,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [1:0] SYNC = 2'd0, ARB = 2'd1, ACC = 2'd2;
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  localparam logic [3:0] MB = 4'(MAX_BURST);

  logic [1:0]        state;
  logic              sync_cnt;
  logic [2:0]        wait_cnt;
  logic [3:0]        burst;
  logic              last_dma;
  logic              own_dma;
  logic [DATA_W-1:0] din_q;
  logic              cpu_req, arb, acc_last, dma_win, grant_dma, grant_cpu, lock_hold;

  assign cpu_req   = cpu_vpa | cpu_vda | cpu_vio;
  assign arb       = state == ARB;
  assign acc_last  = state == ACC && wait_cnt == WS;
  assign dma_win   = dma_req & ~lock_hold & (~last_dma | ~cpu_req | (burst < MB));
  assign grant_dma = arb & dma_win;
  assign grant_cpu = arb & ~dma_win & cpu_req;

  // The CPU only advances in SYNC, idle ARB cycles and the last cycle of its own access.
  assign cpu_clken   = state == SYNC | (arb & ~grant_dma & ~grant_cpu) | (acc_last & ~own_dma);
  assign cpu_din     = (acc_last & ~own_dma) ? mem_rdata : din_q;
  assign dma_ack     = acc_last & own_dma;
  assign dma_rdata   = mem_rdata;
  assign mem_cs      = state == ACC;
  assign mem_io      = ~own_dma & cpu_vio;
  assign mem_rnw     = own_dma ? dma_rnw : cpu_rnw;
  assign mem_address = own_dma ? dma_address : cpu_address;
  assign mem_wdata   = own_dma ? dma_wdata : cpu_dout;

`ifdef ARB_CPU_LOCK_EN
  logic [6:0] lock_cnt;
  // A lock seen for 64 ARB cycles (bit 6 set) is overridden for one grant.
  assign lock_hold = cpu_lock & ~last_dma & ~lock_cnt[6];
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) lock_cnt <= '0;
    else if (arb) lock_cnt <= (!cpu_lock || (lock_cnt[6] && (grant_dma || grant_cpu))) ? '0 : lock_cnt + {6'd0, ~lock_cnt[6]};
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state    <= SYNC;
      sync_cnt <= 1'b0;
      wait_cnt <= '0;
      burst    <= '0;
      last_dma <= 1'b0;
      own_dma  <= 1'b0;
    end else begin
      if (state == SYNC) begin
        sync_cnt <= 1'b1;
        if (sync_cnt) state <= ARB;
      end
      if (arb) begin
        if (grant_dma || grant_cpu) begin
          state    <= ACC;
          own_dma  <= grant_dma;
          wait_cnt <= '0;
        end
        if (grant_cpu || !dma_req) burst <= '0;
      end
      if (state == ACC) begin
        wait_cnt <= wait_cnt + 3'd1;
        if (acc_last) begin
          state    <= ARB;
          last_dma <= own_dma;
          if (own_dma && burst < MB) burst <= burst + 4'd1;
        end
      end
      if (state == 2'd3) state <= SYNC;
    end

  always_ff @(posedge clk)
    if (acc_last && !own_dma) din_q <= mem_rdata;
endmodule

// File: doc/opc7_bus_arbiter.md
Name: opc7_bus_arbiter

Overview:
- Shares one 32-bit synchronous memory/IO port between the opc7 CPU and a single DMA requester.
- Throttles the CPU by gating its clock enable (`cpu_clken`).
- Inserts a configurable number of memory wait states.
- Alternates ownership with a bounded DMA burst so neither requester starves.
- Sits between the CPU bus pins and the board memory/IO decode.

Parameters:
- ADDR_W, 20, address width (matches CPU address bus)
- DATA_W, 32, data width
- WAIT_STATES, 1, extra memory cycles per access (0..7)
- MAX_BURST, 4, maximum consecutive DMA accesses before the CPU must be served (1..15)

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- cpu_vpa  in  1  CPU instruction/operand fetch request
- cpu_vda  in  1  CPU memory data request
- cpu_vio  in  1  CPU IO request
- cpu_rnw  in  1  CPU read(1)/write(0)
- cpu_address  in  ADDR_W  CPU address
- cpu_dout  in  DATA_W  CPU write data
- cpu_din  out  DATA_W  read data to CPU
- cpu_clken  out  1  CPU clock enable
- dma_req  in  1  DMA access request, held until `dma_ack`
- dma_rnw  in  1  DMA read(1)/write(0)
- dma_address  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_ack  out  1  one-cycle pulse: DMA access complete
- dma_rdata  out  DATA_W  DMA read data, valid with `dma_ack`
- mem_cs  out  1  memory/IO cycle active
- mem_io  out  1  cycle targets IO space (CPU `vio` only)
- mem_rnw  out  1  read(1)/write(0)
- mem_address  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid in the last access cycle

Behaviour:
- States: SYNC, ARB, ACC.
- Reset (`reset_b` low, asynchronous):
  - state=SYNC, sync counter=0, burst count=0, last_owner=CPU.
  - mem_cs=0, dma_ack=0, cpu_clken=1. The CPU's internal reset synchroniser needs enabled clocks.
- SYNC:
  - cpu_clken=1, mem_cs=0 for 2 cycles after reset release; then go to ARB.
  - No CPU request is serviced during SYNC.
- ARB (decision made each cycle; cpu_req = vpa|vda|vio):
  - dma_req and (last_owner==CPU or !cpu_req or burst<MAX_BURST while last_owner==DMA): grant DMA, go to ACC.
  - else cpu_req: grant CPU, burst:=0, go to ACC.
  - else !cpu_req and !dma_req: cpu_clken=1 for this cycle (CPU internal/EAD cycle); stay in ARB.
  - cpu_clken=0 in ARB whenever a grant is issued.
- ACC:
  - Lasts WAIT_STATES+1 cycles, counted by a wait counter.
  - mem_cs=1 and mem_* driven from the owner for the whole of ACC. CPU requester inputs are stable because the CPU is frozen.
  - mem_io = cpu_vio for CPU grants, 0 for DMA grants.
  - Last cycle, CPU owner: cpu_clken=1, cpu_din=mem_rdata; last_owner:=CPU.
  - Last cycle, DMA owner: dma_ack=1, dma_rdata=mem_rdata; burst:=burst+1 (saturates at MAX_BURST); last_owner:=DMA.
  - Return to ARB. No back-to-back overlap: every access costs 1 ARB + WAIT_STATES+1 cycles.
- DMA burst rules:
  - With both requesting, DMA gets up to MAX_BURST accesses, then exactly one CPU access, then DMA again.
  - burst resets to 0 on any CPU grant and on any ARB cycle with dma_req low.
- cpu_clken is 0 in every cycle other than those listed above. cpu_din holds its last value when not driven.
- Write cycles: mem_wdata = cpu_dout or dma_wdata. Read data is ignored by the arbiter.
- dma_req dropped during ACC: the access still completes and dma_ack still pulses. The DMA is required not to do this.
- Asynchronous reset mid-ACC:
  - The access is aborted immediately: mem_cs=0, no ack, no clken.
  - The DMA must reissue the access.

Optional Feature:
- Macro ARB_CPU_LOCK_EN.
- When defined:
  - Extra input `cpu_lock` (1 bit).
  - While `cpu_lock` is high in ARB and the CPU is last owner, DMA is never granted; the CPU keeps the bus for read-modify-write sequences.
  - A lock held over 64 consecutive ARB cycles is ignored for one grant, so a stuck lock cannot block DMA forever.
- When undefined: no port, and arbitration is exactly as above.

Test Plan:
- Reset release, WAIT_STATES=1, CPU fetching, no DMA -> cpu_clken=1 for 2 SYNC cycles, then a repeating pattern of 0,0,1 (ARB, ACC, ACC-last); mem_address equals CPU PC each access.
- CPU idle (vpa=vda=vio=0) and dma_req=0 -> cpu_clken=1 every cycle, mem_cs=0.
- MAX_BURST=4, CPU and DMA requesting continuously -> grant order DMA×4, CPU×1, DMA×4…; dma_ack pulses 4 times, then cpu_clken pulses once.
- DMA read at 0x00123 with mem_rdata=0xDEADBEEF -> dma_ack=1 and dma_rdata=0xDEADBEEF in the same cycle, WAIT_STATES+2 cycles after dma_req rises from ARB.
- CPU OUT (vio=1, rnw=0, data 0x5A) -> mem_io=1, mem_rnw=0, mem_wdata=0x5A for WAIT_STATES+1 cycles.
- reset_b pulsed low during a DMA ACC -> mem_cs=0 and dma_ack=0 immediately; SYNC repeats; the reissued DMA access completes normally.
